// File: rtl/rbm_input_loader_pkg.sv
// Shared constants and state encoding for the RBM input loader and the layer it feeds.
package rbm_input_loader_pkg;

  typedef enum logic {
    LOAD    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // The RBM layer uses the same defaults, so the two widths always agree.
  localparam int DEF_BITLENGTH       = 12;
  localparam int DEF_INPUT_DIM       = 15;
  localparam int DEF_PIXEL_BITLENGTH = 8;
  localparam int DEF_COUNT_BITLENGTH = 16;

  function automatic int cursor_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/rbm_frame_buffer.sv
// One bank of binarized visible units: write a slot, optionally clear the tail, read packed.
module rbm_frame_buffer #(
  parameter int bitlength = 12,
  parameter int input_dim = 15,
  parameter int CW        = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en_i,
  input  logic [CW-1:0]                  wr_idx_i,
  input  logic                           wr_bit_i,
  input  logic                           clr_tail_i,
  output logic [input_dim*bitlength-1:0] rd_data_o
);

  logic [input_dim-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (wr_en_i) begin
      for (int k = 0; k < input_dim; k++) begin
        if (k == int'(wr_idx_i))
          slot_d[k] = wr_bit_i;
        else if (clr_tail_i && (k > int'(wr_idx_i)))
          slot_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  // Each slot holds a single bit, zero-extended to the layer's slot width.
  for (genvar k = 0; k < input_dim; k++) begin : g_slot
    assign rd_data_o[k*bitlength +: bitlength] = bitlength'(slot_q[k]);
  end

endmodule

// File: rtl/rbm_input_loader.sv
// Binarizes a serial pixel stream into the RBM layer's packed visible vector.
// Define RBM_LOADER_DOUBLE_BUFFER_EN to load the next frame while the current one is presented.
module rbm_input_loader
  import rbm_input_loader_pkg::*;
#(
  parameter int                         bitlength       = DEF_BITLENGTH,
  parameter int                         pixel_bitlength = DEF_PIXEL_BITLENGTH,
  parameter int                         input_dim       = DEF_INPUT_DIM,
  parameter logic [pixel_bitlength-1:0] threshold       = pixel_bitlength'(128),
  parameter int                         count_bitlength = DEF_COUNT_BITLENGTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [pixel_bitlength-1:0]     PixelData,
  input  logic                           pixel_valid,
  input  logic                           pixel_last,
  output logic                           pixel_ready,
  output logic [input_dim*bitlength-1:0] OutputData,
  output logic                           data_valid,
  input  logic                           layer_finish,
  output logic [count_bitlength-1:0]     frame_count,
  output logic                           short_frame
);

  localparam int CW = cursor_width(input_dim);
  localparam logic [CW-1:0] LAST_IDX = CW'(input_dim - 1);

`ifdef RBM_LOADER_DOUBLE_BUFFER_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  logic [CW-1:0]              cursor_q;
  logic                       ready_q, valid_q, short_q;
  logic [count_bitlength-1:0] count_q;
  logic                       acc, last_slot, frame_end, clr_tail, wr_bit;
  logic                       fill_sel;
  logic [NBANK-1:0][input_dim*bitlength-1:0] bank_data;

  assign acc       = pixel_valid & ready_q;
  assign last_slot = (cursor_q == LAST_IDX);
  // pixel_last is ignored on the slot that completes the frame anyway.
  assign clr_tail  = pixel_last & ~last_slot;
  assign frame_end = acc & (last_slot | pixel_last);
  assign wr_bit    = (PixelData >= threshold);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cursor_q <= '0;
      short_q  <= 1'b0;
    end else begin
      if (frame_end)  cursor_q <= '0;
      else if (acc)   cursor_q <= cursor_q + 1'b1;
      if (acc && clr_tail) short_q <= 1'b1;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    rbm_frame_buffer #(
      .bitlength (bitlength),
      .input_dim (input_dim),
      .CW        (CW)
    ) u_buf (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (acc & (fill_sel == 1'(b))),
      .wr_idx_i   (cursor_q),
      .wr_bit_i   (wr_bit),
      .clr_tail_i (clr_tail),
      .rd_data_o  (bank_data[b])
    );
  end

`ifdef RBM_LOADER_DOUBLE_BUFFER_EN
  logic front_q, fill_q, pend_q, full_q, full_d;

  assign fill_sel   = fill_q;
  assign OutputData = bank_data[front_q];

  // full: the fill bank holds a finished frame waiting behind the front bank.
  always_comb begin
    full_d = full_q;
    if (valid_q & layer_finish)          full_d = 1'b0;
    else if (frame_end & (valid_q | pend_q)) full_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      front_q <= 1'b0;
      fill_q  <= 1'b0;
      pend_q  <= 1'b0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_d;
      pend_q  <= 1'b0;
      if (valid_q & layer_finish) begin
        valid_q <= 1'b0;
        // Swap now; data_valid comes back after a one-cycle gap.
        if (full_q | frame_end) begin
          front_q <= fill_q;
          fill_q  <= ~fill_q;
          pend_q  <= 1'b1;
        end
      end else if (pend_q) begin
        valid_q <= 1'b1;
        count_q <= count_q + 1'b1;
      end else if (frame_end & ~valid_q) begin
        front_q <= fill_q;
        fill_q  <= ~fill_q;
        valid_q <= 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end
`else
  state_e state_q;

  assign fill_sel   = 1'b0;
  assign OutputData = bank_data[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          ready_q <= 1'b1;
          if (frame_end) begin
            state_q <= PRESENT;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            count_q <= count_q + 1'b1;
          end
        end
        PRESENT: begin
          if (layer_finish) begin
            state_q <= LOAD;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end
`endif

  assign pixel_ready = ready_q;
  assign data_valid  = valid_q;
  assign frame_count = count_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_rbm_input_loader.sv
// Bench for rbm_input_loader: directed frames plus random streams against a frame-level model.
module tb_rbm_input_loader;
  localparam int DIM = 15;
  localparam int BL  = 12;
  localparam int W   = DIM * BL;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   PixelData = '0;
  logic         pixel_valid = 1'b0, pixel_last = 1'b0, layer_finish = 1'b0;
  logic         pixel_ready, data_valid, short_frame;
  logic [W-1:0] OutputData;
  logic [15:0]  frame_count;

  rbm_input_loader dut (
    .clock        (clock),
    .reset        (reset),
    .PixelData    (PixelData),
    .pixel_valid  (pixel_valid),
    .pixel_last   (pixel_last),
    .pixel_ready  (pixel_ready),
    .OutputData   (OutputData),
    .data_valid   (data_valid),
    .layer_finish (layer_finish),
    .frame_count  (frame_count),
    .short_frame  (short_frame)
  );

  always #5 clock = ~clock;

  int errs = 0, checks = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: one completed frame as the layer should see it.
  typedef struct {
    logic [W-1:0] vec;
    logic         shrt;
    int           cnt;
    int           due;
  } exp_t;
  exp_t sbq[$];

  // Reference model: collect binarized pixels; a frame ends at DIM pixels or on pixel_last.
  bit   mbits[$];
  bit   m_short = 0;
  int   m_cnt = 0;
  exp_t m_e;
  always @(negedge clock) begin
    if (reset) begin
      mbits.delete();
      sbq.delete();
      m_short = 0;
      m_cnt = 0;
    end else if (pixel_valid && pixel_ready) begin
      mbits.push_back(PixelData >= 8'd128);
      if (mbits.size() == DIM || pixel_last) begin
        m_e.vec = '0;
        for (int i = 0; i < mbits.size(); i++) m_e.vec[i*BL] = mbits[i];
        if (mbits.size() < DIM) m_short = 1;
        m_cnt = (m_cnt + 1) % 65536;
        m_e.shrt = m_short;
        m_e.cnt  = m_cnt;
        m_e.due  = cyc + 1;
        sbq.push_back(m_e);
        mbits.delete();
      end
    end
  end

  // Monitor: compare each presented frame, its hold, and the finish handshake.
  logic         prev_dv = 1'b0, prev_fin = 1'b0;
  logic [W-1:0] held = '0;
  exp_t         mon_e;
  always @(negedge clock) begin
    if (reset) begin
      prev_dv  = 1'b0;
      prev_fin = 1'b0;
    end else begin
      if (data_valid && !prev_dv) begin
        if (sbq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_present: got data_valid=1 expected no frame (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("frame_latency", 192'(cyc), 192'(mon_e.due));
          chk("frame_data", 192'(OutputData), 192'(mon_e.vec));
          chk("frame_count", 192'(frame_count), 192'(mon_e.cnt));
          chk("short_frame", 192'(short_frame), 192'(mon_e.shrt));
        end
        held = OutputData;
      end else if (data_valid && prev_dv) begin
        chk("hold_stable", 192'(OutputData), 192'(held));
      end
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
        checks++; errs++;
        $display("FAIL present_timeout: got data_valid=0 expected 1 (cycle %0d)", cyc);
        void'(sbq.pop_front());
      end
      if (prev_dv && prev_fin) begin
        chk("finish_dv", 192'(data_valid), 192'(0));
        chk("finish_ready", 192'(pixel_ready), 192'(1));
      end
      if (data_valid) chk("ready_in_present", 192'(pixel_ready), 192'(0));
      prev_dv  = data_valid;
      prev_fin = layer_finish;
    end
  end

  // Random finish generator, runs just after the directed driver each cycle.
  bit fin_auto = 0;
  initial forever begin
    @(posedge clock); #2;
    if (fin_auto) layer_finish = ($urandom_range(2) == 0);
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    pixel_valid = 1'b0; pixel_last = 1'b0;
    #1;
    chk("rst_data", 192'(OutputData), 192'(0));
    chk("rst_dv", 192'(data_valid), 192'(0));
    chk("rst_ready", 192'(pixel_ready), 192'(0));
    chk("rst_count", 192'(frame_count), 192'(0));
    chk("rst_short", 192'(short_frame), 192'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("ready_after_release", 192'(pixel_ready), 192'(0));
    @(posedge clock); #1;
    chk("ready_first_edge", 192'(pixel_ready), 192'(1));
  endtask

  task automatic send_pixel(input logic [7:0] v, input logic last);
    int n = 0;
    PixelData = v; pixel_last = last; pixel_valid = 1'b1;
    @(negedge clock);
    while (!pixel_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!pixel_ready) begin
      checks++; errs++;
      $display("FAIL send_timeout: got pixel_ready=0 expected 1 (cycle %0d)", cyc);
    end
    @(posedge clock); #1;
    pixel_valid = 1'b0; pixel_last = 1'b0;
  endtask

  task automatic finish_pulse();
    int n = 0;
    while (!data_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("present_before_finish", 192'(data_valid), 192'(1));
    layer_finish = 1'b1;
    @(posedge clock); #1;
    layer_finish = 1'b0;
  endtask

  logic [7:0] rv;
  initial begin
    do_reset();

    // Alternating 200/10, then try to push pixels while presenting.
    for (int i = 0; i < DIM; i++) send_pixel((i % 2 == 0) ? 8'd200 : 8'd10, 1'b0);
    chk("dv_after_full", 192'(data_valid), 192'(1));
    PixelData = 8'd255; pixel_valid = 1'b1;
    repeat (5) @(posedge clock);
    #1 pixel_valid = 1'b0;
    finish_pulse();

    // Threshold boundaries, then fill the rest of the frame.
    send_pixel(8'd127, 1'b0); send_pixel(8'd128, 1'b0);
    send_pixel(8'd0, 1'b0);   send_pixel(8'd255, 1'b0);
    for (int i = 4; i < DIM; i++) send_pixel(8'($urandom_range(255)), 1'b0);
    finish_pulse();

    // Short frame of four bright pixels.
    for (int i = 0; i < 4; i++) send_pixel(8'd255, i == 3);
    finish_pulse();

    // Reset in the middle of a frame, then a full dark frame.
    for (int i = 0; i < 7; i++) send_pixel(8'd255, 1'b0);
    do_reset();
    for (int i = 0; i < DIM; i++) send_pixel(8'd0, 1'b0);
    finish_pulse();

    // Single-pixel frame, then pixel_last on the final slot (ignored).
    send_pixel(8'd129, 1'b1);
    finish_pulse();
    for (int i = 0; i < DIM; i++) send_pixel(8'd140, i == DIM - 1);
    finish_pulse();

    // Random streaming with random finishes and gaps.
    fin_auto = 1;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(5))
        0: rv = 8'd127;
        1: rv = 8'd128;
        2: rv = 8'd0;
        3: rv = 8'd255;
        default: rv = 8'($urandom_range(255));
      endcase
      send_pixel(rv, $urandom_range(9) == 0);
      if ($urandom_range(3) == 0) begin
        @(posedge clock); #1;
      end
    end

    for (int i = 0; i < 300 && sbq.size() > 0; i++) @(posedge clock);
    repeat (5) @(posedge clock);
    chk("scoreboard_drained", 192'(sbq.size()), 192'(0));
    fin_auto = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rbm_input_loader.md
Name: rbm_input_loader

Overview:
Upstream feeder for the RBM hidden layer. Accepts a serial pixel stream over a valid/ready handshake and binarizes each pixel against a threshold. Packs the results into the layer's input_dim x bitlength visible vector, then holds it with data_valid until the layer reports finish. Sits between the dataset/stream source and the first RBM layer; the layer's InputData, data_valid and finish connect directly to this block.

Parameters:
bitlength, 12, width of each packed visible-unit slot; must match the layer.
pixel_bitlength, 8, width of an incoming pixel.
input_dim, 15, visible units per frame (784 for full MNIST).
threshold, 8'd128, binarization threshold; pixel >= threshold gives 1.
count_bitlength, 16, width of frame_count.

Ports:
clock  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
PixelData  in  pixel_bitlength  current pixel value.
pixel_valid  in  1  PixelData valid this cycle.
pixel_last  in  1  marks the final pixel of a frame.
pixel_ready  out  1  loader can accept a pixel this cycle.
OutputData  out  input_dim*bitlength  packed binary vector; slot k is bits [k*bitlength +: bitlength].
data_valid  out  1  OutputData is complete and stable; drives the layer's data_valid.
layer_finish  in  1  finish from the downstream layer.
frame_count  out  count_bitlength  number of frames handed off; wraps modulo 2^count_bitlength.
short_frame  out  1  sticky; set when pixel_last arrives before input_dim pixels.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - Outputs: OutputData=0, data_valid=0, pixel_ready=0, frame_count=0, short_frame=0.
  - Internal: cursor=0, state=LOAD.
  - The partial frame is discarded.
  - pixel_ready rises on the first clock edge after reset deasserts.
- States:
  - LOAD: pixel_ready=1, data_valid=0.
  - PRESENT: pixel_ready=0, data_valid=1.
- Accept rule: a pixel is accepted when pixel_valid & pixel_ready on a rising edge.
- Slot write on accept: slot[cursor] = 1 (zero-extended to bitlength) if PixelData >= threshold, else 0. Then cursor = cursor+1.
- Frame end is the first of either event:
  - Accept with cursor==input_dim-1. pixel_last is ignored on this accept.
  - Accept with pixel_last=1 and cursor<input_dim-1. Slots cursor+1..input_dim-1 are cleared to 0 in the same edge, and short_frame is set.
- On frame end: state becomes PRESENT and cursor=0 at the same edge, so data_valid is 1 from the edge after the final accept (1-cycle latency). frame_count increments on that edge.
- PRESENT:
  - OutputData is held bit-stable.
  - Exits to LOAD on the first edge where layer_finish=1; data_valid is 0 after that edge.
  - pixel_ready returns to 1 on the same edge; there is no bubble cycle.
- layer_finish sampled in LOAD has no effect.
- pixel_valid while pixel_ready=0 is not accepted. The source must hold the pixel.
- A single-pixel frame (pixel_last on the first accept) gives slot0 = binarized value, all other slots 0, and short_frame=1.
- frame_count wraps from all-ones to 0 with no flag.

Optional Feature:
RBM_LOADER_DOUBLE_BUFFER_EN
- Defined:
  - Two banks. LOAD fills the back bank while the front bank is presented, so pixel_ready stays 1 during PRESENT until the back bank is full.
  - Back bank full and front still presenting: pixel_ready=0.
  - On layer_finish: swap banks. data_valid falls for exactly 1 cycle, then rises with the new front if it is full; otherwise it stays 0 until the frame completes.
  - frame_count increments on each handoff.
- Undefined: single bank, behaviour exactly as above.

Decomposition:
- Shared header config.v:
  - PORT_1D and GET_1D packing macros.
  - State encodings LOAD=1'b0, PRESENT=1'b1.
  - Default bitlength and input_dim constants, shared with the RBM layer so widths always agree.
- One natural sub-module, rbm_frame_buffer: a single bank with write-slot/clear-tail/read-packed behaviour. It is instantiated once, or twice under RBM_LOADER_DOUBLE_BUFFER_EN.

Test Plan (input_dim=15, threshold=128):
- Reset then 15 pixels, alternating 200/10, with pixel_valid held high → slots 0,2,..14 =1, odd slots =0. data_valid=1 at the edge after the 15th accept; frame_count=1; pixel_ready=0.
- In PRESENT, drive pixel_valid=1 with 255 for 5 cycles, then layer_finish=1 for 1 cycle → OutputData unchanged throughout, no pixel accepted, data_valid=0 and pixel_ready=1 on the edge after finish.
- Boundary values 127, 128, 0, 255 → slots 0, 1, 0, 1.
- 4 pixels of 255 with pixel_last on the 4th → slots 0..3 =1, slots 4..14 =0, short_frame=1, data_valid=1 on the next edge.
- Assert reset after 7 accepts, release, then send 15 pixels of 0 → OutputData all 0, frame_count=1, short_frame=0.
- With RBM_LOADER_DOUBLE_BUFFER_EN: present frame A, stream frame B fully while A is presented, then layer_finish → data_valid low 1 cycle, then OutputData=B, frame_count=2.
